// File: rtl/flippy_column_array.sv
// Flippy Bit game engine: NUM_COLS falling target columns with LFSR spawning,
// match detection, saturating score, lives and an IDLE/RUN/OVER controller.
module flippy_column_array #(
   parameter int NUM_COLS    = 3,
   parameter int DATA_W      = 8,
   parameter int YPOS_W      = 5,
   parameter int FLOOR_ROW   = 29,
   parameter int SPAWN_TICKS = 4,
   parameter int LIVES       = 3,
   parameter int SCORE_W     = 8
) (
   input  logic                       CLOCK_50,
   input  logic                       reset_button,
   input  logic                       tick,
   input  logic                       start,
   input  logic                       submit,
   input  logic [DATA_W-1:0]          user_input,
   output logic [NUM_COLS*DATA_W-1:0] letters,
   output logic [NUM_COLS*YPOS_W-1:0] ypos,
   output logic [NUM_COLS-1:0]        active,
   output logic [SCORE_W-1:0]         score,
   output logic [3:0]                 lives,
   output logic                       game_over,
   output logic                       correct,
   output logic                       wrong
);

   localparam int                 CNT_W      = $clog2(SPAWN_TICKS + 1);
   localparam int                 IDX_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [YPOS_W-1:0]  FLOOR_Y    = YPOS_W'(FLOOR_ROW);
   localparam logic [CNT_W-1:0]   SPAWN_LAST = CNT_W'(SPAWN_TICKS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
   localparam logic [15:0]        LFSR_SEED  = 16'hACE1;
   // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 in a right-shifting register.
   localparam logic [15:0]        LFSR_TAPS  = 16'hB400;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_e;

   state_e              state_q, state_d;
   logic                enter_run, in_run;

   logic [15:0]         lfsr_q, lfsr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_COLS-1:0] active_q, active_d;
   logic [YPOS_W-1:0]   ypos_q   [NUM_COLS];
   logic [YPOS_W-1:0]   ypos_d   [NUM_COLS];
   logic [DATA_W-1:0]   letter_q [NUM_COLS];
   logic [DATA_W-1:0]   letter_d [NUM_COLS];
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [3:0]          lives_q, lives_d;
   logic                game_over_q;
   logic                correct_q, correct_d;
   logic                wrong_q, wrong_d;

   logic                found;
   logic [IDX_W-1:0]    win_idx;
   logic [YPOS_W-1:0]   win_y;
   logic                hit;
   logic [3:0]          misses;
   logic                spawned;
   logic [DATA_W-1:0]   spawn_letter;

   // ---------------- controller ----------------
   // NOTE: sequential state is only ever assigned with <=, so every flop samples
   // the pre-edge value of every other flop regardless of process ordering.
   always_ff @(posedge CLOCK_50 or negedge reset_button) begin
      if (!reset_button) state_q <= S_IDLE;
      else               state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (lives_d == '0) state_d = S_OVER;
         S_OVER:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      enter_run = 1'b0;
      in_run    = 1'b0;
      case (state_q)
         S_IDLE, S_OVER: enter_run = start;
         S_RUN:          in_run    = 1'b1;
         default:        ;
      endcase
   end

   // ---------------- match search ----------------
   // Strict '>' keeps the lowest index on equal row positions.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      win_y   = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (active_q[i] && (letter_q[i] == user_input) && (!found || (ypos_q[i] > win_y))) begin
            found   = 1'b1;
            win_idx = IDX_W'(i);
            win_y   = ypos_q[i];
         end
      end
   end

   assign hit = in_run && submit && found;

   // ---------------- columns and spawning ----------------
   // NOTE: every variable driven here gets a default first so no path leaves
   // it unassigned; a missing default is what turns always_comb into a latch.
   always_comb begin
      active_d     = active_q;
      ypos_d       = ypos_q;
      letter_d     = letter_q;
      cnt_d        = cnt_q;
      misses       = '0;
      spawned      = 1'b0;
      spawn_letter = (lfsr_q[DATA_W-1:0] == '0) ? DATA_W'(1) : lfsr_q[DATA_W-1:0];

      if (enter_run) begin
         active_d = '0;
         cnt_d    = '0;
         for (int i = 0; i < NUM_COLS; i++) ypos_d[i] = '0;
      end else if (in_run) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            if (hit && (win_idx == IDX_W'(i))) begin
               active_d[i] = 1'b0;
               ypos_d[i]   = '0;
            end else if (tick && active_q[i]) begin
               if (ypos_q[i] == FLOOR_Y) begin
                  active_d[i] = 1'b0;
                  ypos_d[i]   = '0;
                  misses      = misses + 4'd1;
               end else begin
                  ypos_d[i] = ypos_q[i] + YPOS_W'(1);
               end
            end
         end
         // Spawn looks at active_d so columns freed this cycle are reusable.
         if (tick) begin
            if (cnt_q == SPAWN_LAST) begin
               cnt_d = '0;
               for (int i = 0; i < NUM_COLS; i++) begin
                  if (!spawned && !active_d[i]) begin
                     active_d[i] = 1'b1;
                     ypos_d[i]   = '0;
                     letter_d[i] = spawn_letter;
                     spawned     = 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   // ---------------- score, lives, pulses ----------------
   always_comb begin
      score_d   = score_q;
      lives_d   = lives_q;
      correct_d = 1'b0;
      wrong_d   = 1'b0;
      if (enter_run) begin
         score_d = '0;
         lives_d = LIVES_INIT;
      end else if (in_run) begin
         if (hit && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
         lives_d   = (lives_q > misses) ? (lives_q - misses) : '0;
         correct_d = hit;
         wrong_d   = submit && !found;
      end
   end

   assign lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LFSR_TAPS) : {1'b0, lfsr_q[15:1]};

   // NOTE: the column arrays are reset along with everything else because
   // they drive the display buses directly and must come up as zeros.
   always_ff @(posedge CLOCK_50 or negedge reset_button) begin
      if (!reset_button) begin
         lfsr_q      <= LFSR_SEED;
         cnt_q       <= '0;
         active_q    <= '0;
         score_q     <= '0;
         lives_q     <= LIVES_INIT;
         game_over_q <= 1'b0;
         correct_q   <= 1'b0;
         wrong_q     <= 1'b0;
         for (int i = 0; i < NUM_COLS; i++) begin
            ypos_q[i]   <= '0;
            letter_q[i] <= '0;
         end
      end else begin
         lfsr_q      <= lfsr_d;
         cnt_q       <= cnt_d;
         active_q    <= active_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         game_over_q <= (state_d == S_OVER);
         correct_q   <= correct_d;
         wrong_q     <= wrong_d;
         ypos_q      <= ypos_d;
         letter_q    <= letter_d;
      end
   end

   for (genvar g = 0; g < NUM_COLS; g++) begin : g_flat
      assign letters[g*DATA_W +: DATA_W] = letter_q[g];
      assign ypos[g*YPOS_W +: YPOS_W]    = ypos_q[g];
   end

   assign active    = active_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign game_over = game_over_q;
   assign correct   = correct_q;
   assign wrong     = wrong_q;

endmodule

// File: doc/flippy_column_array.md
Name: flippy_column_array

Overview:
Parametrised game engine for Flippy Bit. It replaces the single hard-wired column with NUM_COLS falling columns, each carrying a DATA_W-bit target value. The block owns spawning (LFSR), falling, match detection, score, lives and the run/over state machine. It sits between the clock divider/switch inputs and the display/framebuffer builder, and exports flattened letter and ypos buses.

Parameters:
NUM_COLS, 3, number of independent falling columns (1..8)
DATA_W, 8, width of each target value and of user_input
YPOS_W, 5, width of each column row position
FLOOR_ROW, 29, last visible row; a column at this row on a tick is a miss
SPAWN_TICKS, 4, ticks between spawn attempts (>=1)
LIVES, 3, lives at game start (>=1)
SCORE_W, 8, score width, saturating

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset_button  input  1  asynchronous active-low reset
tick  input  1  one-cycle fall-rate enable from clock divider
start  input  1  one-cycle pulse: start or restart game
submit  input  1  one-cycle pulse: evaluate user_input (synchronised upstream)
user_input  input  DATA_W  switch value
letters  output  NUM_COLS*DATA_W  column i value at [i*DATA_W +: DATA_W]
ypos  output  NUM_COLS*YPOS_W  column i row at [i*YPOS_W +: YPOS_W]
active  output  NUM_COLS  column i occupied
score  output  SCORE_W  current score
lives  output  4  remaining lives
game_over  output  1  high while in OVER
correct  output  1  one-cycle pulse on a successful match
wrong  output  1  one-cycle pulse on a submit with no match

Behaviour:
- Reset (async, reset_button=0): state IDLE; score 0; lives=LIVES; active 0; all ypos 0; all letters 0; correct/wrong/game_over 0; spawn counter 0; LFSR 16'hACE1. All registered outputs.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clock in all states.
- FSM: IDLE -start-> RUN. RUN -lives reach 0-> OVER (next edge). OVER -start-> RUN. In RUN, start is ignored.
- Entry to RUN (from IDLE or OVER): score 0, lives=LIVES, active 0, spawn counter 0.
- IDLE/OVER: tick and submit are ignored; outputs hold; game_over=1 only in OVER.
- Tick in RUN:
  - every active column with ypos<FLOOR_ROW increments ypos by 1;
  - an active column with ypos==FLOOR_ROW is cleared (active=0, ypos 0) and lives decrements by 1;
  - multiple misses on one tick each cost a life; lives floor at 0.
- Spawn in RUN: the spawn counter increments on each tick. On the tick where counter==SPAWN_TICKS-1 the counter clears and the lowest-index inactive column is loaded: active=1, ypos=0, letter=LFSR[DATA_W-1:0] (0 is replaced by 1). If all columns are active the spawn is skipped and the counter still clears. A column freed by a miss on the same tick is eligible for spawn.
- Submit in RUN:
  - user_input is compared against all active columns using pre-tick state;
  - winner: largest ypos, ties to lowest index;
  - winner is cleared, score+1 saturating at 2^SCORE_W-1, correct=1 on the next cycle;
  - no match: wrong=1 on the next cycle, no other change.
- Simultaneous submit and tick:
  - the matched column is cleared and is not moved or counted as a miss, even at FLOOR_ROW;
  - other columns fall normally;
  - a cleared column is eligible for spawn that cycle.
- Lives reaching 0 and a correct submit in the same cycle: the score updates and the FSM still enters OVER.
- Latency: all effects are visible one clock after the qualifying input edge.

Test Plan:
- Reset, start, 4 ticks -> active=3'b001, ypos0=0, letter0 nonzero = LFSR low byte; 3 more ticks -> ypos0=3, no further spawn until tick 8 (column 1).
- Column 0 letter=L, submit with user_input=L -> correct pulse 1 cycle, score=1, active[0]=0; submit with L^8'h01 -> wrong pulse, score unchanged.
- Spawn, let column fall: ypos0 reaches 29, next tick -> active[0]=0, lives 3->2; with SPAWN_TICKS=40, three misses -> game_over=1, further ticks/submits change nothing, start -> score 0, lives 3, game_over 0.
- Column at ypos 29 with submit matching and tick in the same cycle -> correct=1, score+1, lives unchanged.
- SCORE_W=4: 16 successful matches -> score holds at 15, correct still pulses.
- Assert reset_button mid-RUN between clock edges -> all outputs return to reset values immediately; after release, FSM in IDLE until start.
